// File: rtl/mips_lsu.sv
// Load/store unit for a MIPS-style core: aligns and byte-enables accesses onto a
// big-endian XLEN-wide memory port, extends loads, and times out stalled requests.
module mips_lsu #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   rdata,
   output logic              misaligned,
   output logic              bus_err,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic          store;
      logic          uns;
      logic [1:0]    size;
      logic [OW-1:0] off;
   } acc_t;

   state_t        state;
   acc_t          cur;
   acc_t          in_acc;
   logic [CW-1:0] cnt;

   logic            illegal, misal;
   logic [NB-1:0]   be_c;
   logic [XLEN-1:0] wd_c;
   logic [OW-1:0]   in_bsh, in_hsh, cur_bsh, cur_hsh;
   logic [7:0]      rb;
   logic [15:0]     rh;
   logic [XLEN-1:0] ld_c;

   assign in_acc    = {op[3], op[2], op[1:0], addr[OW-1:0]};
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Lane o sits at the top of the word, so the shift counts lanes from the bottom.
   assign in_bsh  = OW'(NB - 1) - in_acc.off;
   assign in_hsh  = OW'(NB - 2) - in_acc.off;
   assign cur_bsh = OW'(NB - 1) - cur.off;
   assign cur_hsh = OW'(NB - 2) - cur.off;

   always_comb begin
      illegal = (in_acc.size == 2'b11) || (in_acc.store && in_acc.uns);
      misal   = ((in_acc.size == 2'b01) && in_acc.off[0]) ||
                ((in_acc.size == 2'b10) && (in_acc.off != '0));
      be_c    = '1;
      wd_c    = wdata;
      case (in_acc.size)
         2'b00: begin
            be_c = NB'(1) << in_acc.off;
            wd_c = XLEN'(wdata[7:0]) << {in_bsh, 3'b000};
         end
         2'b01: begin
            be_c = NB'(3) << in_acc.off;
            wd_c = XLEN'(wdata[15:0]) << {in_hsh, 3'b000};
         end
         default: ;
      endcase
   end

   always_comb begin
      rb   = 8'(mem_rdata >> {cur_bsh, 3'b000});
      rh   = 16'(mem_rdata >> {cur_hsh, 3'b000});
      ld_c = mem_rdata;
      case (cur.size)
         2'b00:   ld_c = {{(XLEN-8){~cur.uns & rb[7]}}, rb};
         2'b01:   ld_c = {{(XLEN-16){~cur.uns & rh[15]}}, rh};
         default: ;
      endcase
      if (cur.store) ld_c = '0;
   end

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state      <= IDLE;
         cur        <= '0;
         cnt        <= '0;
         resp_valid <= 1'b0;
         rdata      <= '0;
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               cur <= in_acc;
               if (illegal || misal) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  bus_err    <= illegal;
                  misaligned <= ~illegal;
                  rdata      <= '0;
               end else begin
                  state     <= WAIT;
                  cnt       <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= in_acc.store;
                  mem_addr  <= {addr[ADDR_W-1:OW], {OW{1'b0}}};
                  mem_be    <= be_c;
                  mem_wdata <= wd_c;
               end
            end
            WAIT: begin
               // An ack in the final allowed cycle still wins over the timeout.
               if (mem_ack) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  bus_err    <= 1'b0;
                  misaligned <= 1'b0;
                  rdata      <= ld_c;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  bus_err    <= 1'b1;
                  misaligned <= 1'b0;
                  rdata      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               bus_err    <= 1'b0;
               misaligned <= 1'b0;
               rdata      <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_lsu.sv
// Scoreboard bench for mips_lsu: directed corner cases plus random accesses
// checked against a byte-lane reference model.
module tb_mips_lsu;
   localparam int TO = 4;

   logic        clk, rst_b, req_valid, req_ready, resp_valid, misaligned, bus_err, busy;
   logic        mem_req, mem_we, mem_ack;
   logic [3:0]  op, mem_be;
   logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;

   mips_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
      .op(op), .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata),
      .misaligned(misaligned), .bus_err(bus_err), .busy(busy), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata));

   typedef struct {
      logic        mis;
      logic        berr;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   errors = 0, checks = 0, cyc = 0, last_resp = 0;
   bit   chain = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory word viewed as four bytes, lane 0 being the most significant.
   function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input int dly, output bit acc,
                                 output exp_t e, output logic [3:0] be,
                                 output logic [31:0] wexp, output logic [31:0] wmask);
      int n, off, lane;
      bit st, un, ill, mis, timed;
      logic [31:0] v, bytev;
      st  = o[3];
      un  = o[2];
      off = int'(a % 4);
      n   = (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
      ill = (o[1:0] == 2'b11) || (st && un);
      mis = !ill && ((n == 2 && off % 2 == 1) || (n == 4 && off != 0));
      acc = !ill && !mis;
      timed = dly > TO;
      be = '0; wexp = '0; wmask = '0; v = '0;
      if (acc) begin
         for (int j = 0; j < n; j++) begin
            lane = off + j;
            be[lane] = 1'b1;
            wmask |= 32'hFF << (8 * (3 - lane));
            bytev = (wd >> (8 * (n - 1 - j))) & 32'hFF;
            wexp |= bytev << (8 * (3 - lane));
            v = (v << 8) | ((rd >> (8 * (3 - lane))) & 32'hFF);
         end
         if (!un && n < 4 && v[8*n-1]) v |= ~((32'h1 << (8 * n)) - 1);
      end
      e.mis   = mis;
      e.berr  = ill || (acc && timed);
      e.rdata = (acc && !st && !timed) ? v : 32'h0;
      e.cyc   = 0;
   endfunction

   // Drive one access and play the memory; dly = cycle of WAIT on which ack comes (>TO: never).
   task automatic xact(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] rd, input bit hold);
      bit acc;
      exp_t e;
      logic [3:0] be;
      logic [31:0] wexp, wmask;
      int guard, t;
      model(o, a, wd, rd, dly, acc, e, be, wexp, wmask);
      req_valid = 1'b1; op = o; addr = a; wdata = wd;
      guard = 0;
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      if (!req_ready) begin
         chk("accept_wait", 0, 1);
         req_valid = 1'b0;
         return;
      end
      t = cyc;
      if (chain) chk("b2b_accept_cycle", t, last_resp + 1);
      chk("no_memreq_idle", mem_req, 0);
      e.cyc = !acc ? t + 1 : (dly > TO ? t + TO + 1 : t + dly + 1);
      sb.push_back(e);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (!acc) chk("no_memreq_err", mem_req, 0);
      else begin
         for (int c = 1; c <= TO; c++) begin
            chk("mem_req", mem_req, 1);
            chk("req_ready_wait", req_ready, 0);
            chk("mem_addr", mem_addr, {a[31:2], 2'b00});
            chk("mem_we", mem_we, o[3]);
            chk("mem_be", mem_be, be);
            chk("mem_wdata", mem_wdata & wmask, wexp);
            if (c == dly) begin mem_ack = 1'b1; mem_rdata = rd; end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (c == dly) break;
         end
         chk("mem_req_drop", mem_req, 0);
      end
      last_resp = e.cyc;
      chain = 1;
   endtask

   always @(negedge clk) begin
      if (!rst_b && resp_valid) begin
         if (sb.size() == 0) chk("unexpected_resp", 1, 0);
         else begin
            mon_e = sb.pop_front();
            chk("resp_cycle", cyc, mon_e.cyc);
            chk("misaligned", misaligned, mon_e.mis);
            chk("bus_err", bus_err, mon_e.berr);
            chk("rdata", rdata, mon_e.rdata);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ro;
      logic [31:0] ra;
      rst_b = 1'b1; req_valid = 1'b0; op = '0; addr = '0; wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_outputs", {resp_valid, misaligned, bus_err, busy, mem_req, mem_we}, 0);
      chk("rst_buses", {rdata, mem_addr, mem_be, mem_wdata}, 0);
      rst_b = 1'b0;
      @(negedge clk);

      xact(4'b0000, 32'h103, 32'h0, 2, 32'h112233F0, 0);        // LB
      xact(4'b0100, 32'h103, 32'h0, 2, 32'h112233F0, 0);        // LBU
      xact(4'b0001, 32'h202, 32'h0, 1, 32'hAAAA8001, 0);        // LH
      xact(4'b1001, 32'h200, 32'h1234, 3, 32'h0, 0);            // SH
      xact(4'b0010, 32'h101, 32'h0, 1, 32'h0, 0);               // LW misaligned
      xact(4'b0011, 32'h100, 32'h0, 1, 32'h0, 0);               // illegal size
      xact(4'b1110, 32'h100, 32'h0, 1, 32'h0, 0);               // store+unsigned
      xact(4'b0010, 32'h100, 32'h0, TO + 1, 32'h0, 0);          // timeout
      mem_ack = 1'b1;
      @(negedge clk);
      chk("late_ack_idle", busy, 0);
      @(negedge clk);
      mem_ack = 1'b0;
      chk("late_ack_ignored", busy, 0);
      chain = 0;
      xact(4'b0010, 32'h100, 32'h0, TO, 32'hCAFEBABE, 0);       // ack on timeout cycle
      xact(4'b0010, 32'h400, 32'h0, 1, 32'h01020304, 1);        // held req_valid
      xact(4'b0000, 32'h401, 32'h0, 3, 32'h01820304, 1);
      req_valid = 1'b0;
      @(negedge clk);
      chain = 0;

      // Reset while waiting for memory.
      req_valid = 1'b1; op = 4'b0010; addr = 32'h300;
      @(negedge clk);
      req_valid = 1'b0;
      chk("pre_rst_memreq", mem_req, 1);
      @(negedge clk);
      rst_b = 1'b1;
      #1;
      chk("rst_wait_memreq", mem_req, 0);
      chk("rst_wait_ready", req_ready, 1);
      chk("rst_wait_busy", busy, 0);
      mem_ack = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("post_rst_idle", busy, 0);
      chk("post_rst_resp", resp_valid, 0);

      for (int i = 0; i < 300; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (ro[1:0] == 2'b01) ra[0] = 1'b0;
            if (ro[1:0] == 2'b10) ra[1:0] = 2'b00;
            if (ro[3]) ro[2] = 1'b0;
         end
         xact(ro, ra, $urandom, $urandom_range(1, TO + 1), $urandom, $urandom_range(0, 1) == 1);
      end
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
